// File: rtl/oam_dma_pkg.sv
// Shared types, constants and address helpers for the OAM DMA controller.
// Imported by the controller and its bus multiplexer.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADR = 16'hff46;
  localparam int          N_BYTES     = 160;
  localparam logic [15:0] OAM_BASE    = 16'hfe00;
  localparam logic [7:0]  ECHO_BASE   = 8'he0;

  // I/O, HRAM and IE stay reachable by the CPU while a transfer runs.
  function automatic logic is_cpu_allowed(input logic [15:0] adr);
    return adr[15:8] == 8'hff;
  endfunction

  // Sources in the echo window E0..FF read from C0..DF instead.
  function automatic logic [7:0] eff_src(input logic [7:0] src);
    return (src >= ECHO_BASE) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Combinational owner select for the external bus and the OAM port,
// plus CPU read-data return, steered by dma_active.
module oam_dma_bus_mux
  import oam_dma_pkg::is_cpu_allowed;
  import oam_dma_pkg::DMA_REG_ADR;
#(
  parameter int          N_BYTES  = 160,
  parameter logic [15:0] OAM_BASE = 16'hfe00
) (
  input  logic        i_out_en,
  input  logic        i_ce,
  input  logic        i_dma_active,
  input  logic        i_dma_run,
  input  logic [1:0]  i_phase,
  input  logic [15:0] i_dma_adr,
  input  logic [7:0]  i_dma_oam_adr,
  input  logic [7:0]  i_dma_data,
  input  logic [7:0]  i_src_reg,
  input  logic [15:0] i_cpu_adr,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [7:0]  i_cpu_dout,
  input  logic [7:0]  i_ext_din,
  input  logic [7:0]  i_oam_din,
  output logic [7:0]  o_cpu_din,
  output logic [15:0] o_ext_adr,
  output logic        o_ext_rd,
  output logic        o_ext_wr,
  output logic [7:0]  o_ext_dout,
  output logic [7:0]  o_oam_adr,
  output logic        o_oam_wr,
  output logic [7:0]  o_oam_dout
);

  logic w_cpu_hi;
  logic w_cpu_reg;
  logic w_cpu_oam;
  logic w_cpu_hole;

  assign w_cpu_hi   = is_cpu_allowed(i_cpu_adr);
  assign w_cpu_reg  = (i_cpu_adr == DMA_REG_ADR);
  assign w_cpu_oam  = (i_cpu_adr >= OAM_BASE) && (i_cpu_adr < (OAM_BASE + 16'(N_BYTES)));
  assign w_cpu_hole = (i_cpu_adr[15:8] == OAM_BASE[15:8]) && !w_cpu_oam;

  always_comb begin
    o_ext_adr  = 16'h0000;
    o_ext_rd   = 1'b0;
    o_ext_wr   = 1'b0;
    o_ext_dout = 8'h00;
    o_oam_adr  = 8'h00;
    o_oam_wr   = 1'b0;
    o_oam_dout = 8'h00;
    o_cpu_din  = 8'hff;
    if (i_out_en) begin
      if (i_dma_active) begin
        // DMA owns both ports; the CPU only sees FFxx (data path of the bus).
        o_ext_adr  = i_dma_adr;
        o_ext_rd   = i_ce && i_dma_run && (i_phase != 2'd3);
        o_oam_adr  = i_dma_oam_adr;
        o_oam_dout = i_dma_data;
        o_oam_wr   = i_ce && i_dma_run && (i_phase == 2'd3);
        if (w_cpu_reg) begin
          o_cpu_din = i_src_reg;
        end else if (w_cpu_hi) begin
          o_cpu_din = i_ext_din;
        end
      end else begin
        o_ext_adr  = i_cpu_adr;
        o_ext_rd   = i_ce && i_cpu_rd;
        o_ext_wr   = i_ce && i_cpu_wr;
        o_ext_dout = i_cpu_dout;
        o_oam_adr  = i_cpu_adr[7:0];
        o_oam_dout = i_cpu_dout;
        o_oam_wr   = i_ce && i_cpu_wr && w_cpu_oam;
        if (w_cpu_reg) begin
          o_cpu_din = i_src_reg;
        end else if (w_cpu_oam) begin
          o_cpu_din = i_oam_din;
        end else if (w_cpu_hole) begin
          o_cpu_din = 8'h00;
        end else begin
          o_cpu_din = i_ext_din;
        end
      end
    end
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: FF46 write starts a 160-byte copy into OAM, one byte
// per M-cycle, with CPU lockout handled by the bus multiplexer.
module oam_dma_ctrl #(
  parameter int          N_BYTES  = oam_dma_pkg::N_BYTES,
  parameter logic [15:0] OAM_BASE = oam_dma_pkg::OAM_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        t1,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [15:0] ext_adr,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic [7:0]  oam_adr,
  output logic        oam_wr,
  output logic [7:0]  oam_dout,
  input  logic [7:0]  oam_din,
  output logic        dma_active
);
  import oam_dma_pkg::dma_state_t;
  import oam_dma_pkg::IDLE;
  import oam_dma_pkg::START;
  import oam_dma_pkg::XFER;
  import oam_dma_pkg::DMA_REG_ADR;
  import oam_dma_pkg::eff_src;

  localparam logic [7:0] LAST_IDX = 8'(N_BYTES - 1);

  dma_state_t  r_state;
  logic [1:0]  r_tph;
  logic [7:0]  r_cnt;
  logic [7:0]  r_src;
  logic [7:0]  r_xfer_src;
  logic [7:0]  r_data;
  logic        r_active;
  logic        r_out_en;

  logic [1:0]  w_phase;
  logic        w_run;
  logic        w_reg_wr;

  // r_tph remembers the phase of the last enabled T-cycle; t1 re-aligns it.
  assign w_phase  = t1 ? 2'd0 : (r_tph + 2'd1);
  // A byte is in flight during XFER and during a restart's START M-cycle.
  assign w_run    = r_active && (r_cnt <= LAST_IDX);
  assign w_reg_wr = cpu_wr && (cpu_adr == DMA_REG_ADR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_tph      <= 2'd3;
      r_cnt      <= 8'h00;
      r_src      <= 8'hff;
      r_xfer_src <= 8'hff;
      r_data     <= 8'h00;
      r_active   <= 1'b0;
      r_out_en   <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (ce) begin
        r_tph <= w_phase;
        if (w_phase == 2'd2 && w_run) begin
          r_data <= ext_din;
        end
        // End of T4 is the M-cycle boundary: the next state owns the coming T1.
        if (w_phase == 2'd3) begin
          if (w_run) begin
            r_cnt <= r_cnt + 8'd1;
          end
          if (w_reg_wr) begin
            r_src   <= cpu_dout;
            r_state <= START;
          end else begin
            case (r_state)
              START: begin
                r_state    <= XFER;
                r_cnt      <= 8'h00;
                r_xfer_src <= eff_src(r_src);
                r_active   <= 1'b1;
              end
              XFER: begin
                if (r_cnt == LAST_IDX) begin
                  r_state  <= IDLE;
                  r_active <= 1'b0;
                end
              end
              default: begin
              end
            endcase
          end
        end
      end
    end
  end

  assign dma_active = r_active;

  oam_dma_bus_mux #(
    .N_BYTES  (N_BYTES),
    .OAM_BASE (OAM_BASE)
  ) u_bus_mux (
    .i_out_en      (r_out_en),
    .i_ce          (ce),
    .i_dma_active  (r_active),
    .i_dma_run     (w_run),
    .i_phase       (w_phase),
    .i_dma_adr     ({r_xfer_src, r_cnt}),
    .i_dma_oam_adr (r_cnt),
    .i_dma_data    (r_data),
    .i_src_reg     (r_src),
    .i_cpu_adr     (cpu_adr),
    .i_cpu_rd      (cpu_rd),
    .i_cpu_wr      (cpu_wr),
    .i_cpu_dout    (cpu_dout),
    .i_ext_din     (ext_din),
    .i_oam_din     (oam_din),
    .o_cpu_din     (cpu_din),
    .o_ext_adr     (ext_adr),
    .o_ext_rd      (ext_rd),
    .o_ext_wr      (ext_wr),
    .o_ext_dout    (ext_dout),
    .o_oam_adr     (oam_adr),
    .o_oam_wr      (oam_wr),
    .o_oam_dout    (oam_dout)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against an M-cycle-indexed model of
// transfer starts (queue of start M-cycle and effective source page).
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, ce, t1, cpu_rd, cpu_wr;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dout, cpu_din;
  logic [15:0] ext_adr;
  logic        ext_rd, ext_wr;
  logic [7:0]  ext_dout, ext_din;
  logic [7:0]  oam_adr, oam_dout, oam_din;
  logic        oam_wr, dma_active;

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .t1(t1),
    .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .ext_adr(ext_adr), .ext_rd(ext_rd), .ext_wr(ext_wr),
    .ext_dout(ext_dout), .ext_din(ext_din), .oam_adr(oam_adr), .oam_wr(oam_wr),
    .oam_dout(oam_dout), .oam_din(oam_din), .dma_active(dma_active)
  );

  // Memory contents as a fixed function of address; distinct per page and offset.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5a;
  endfunction

  assign ext_din = mem_byte(ext_adr);

  function automatic logic [7:0] ref_eff(input logic [7:0] v);
    return (v >= 8'he0) ? (v - 8'h20) : v;
  endfunction

  int          checks   = 0;
  int          failures = 0;
  int          mc       = 0;
  int          st_m[$];
  logic [7:0]  st_s[$];
  bit          act_prev = 1'b0;
  logic [7:0]  last_src = 8'hff;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (mcycle %0d)", tag, got, exp, mc);
    end
  endtask

  // A transfer started at M-cycle k writes byte i at M-cycle k+2+i; the newest
  // start whose first byte is due wins, older ones keep running until then.
  task automatic model_mcycle(output bit act, output bit valid, output logic [15:0] dadr);
    bit found;
    int idx;
    found = 1'b0;
    valid = 1'b0;
    dadr  = 16'h0000;
    for (int i = st_m.size() - 1; i >= 0; i--) begin
      if (!found && (st_m[i] + 2 <= mc)) begin
        found = 1'b1;
        idx   = mc - st_m[i] - 2;
        if (idx <= 159) begin
          valid = 1'b1;
          dadr  = {st_s[i], 8'(idx)};
        end
      end
    end
    act = valid || ((st_m.size() > 0) && (st_m[st_m.size() - 1] == mc - 1) && act_prev);
  endtask

  task automatic mcycle(input logic [15:0] a, input bit rd, input bit wr,
                        input logic [7:0] d, input int freeze_p);
    bit          act, valid;
    logic [15:0] dadr;
    logic [7:0]  exp_din;
    bit          chk_din;
    model_mcycle(act, valid, dadr);
    oam_din  = 8'($urandom);
    cpu_adr  = a;
    cpu_rd   = rd;
    cpu_wr   = wr;
    cpu_dout = d;
    for (int p = 0; p < 4; p++) begin
      if (p == freeze_p) begin
        ce = 1'b0;
        t1 = (p == 0);
        repeat (3) begin
          @(negedge clk);
          check_val("frz_oam_wr", 32'(oam_wr), 32'd0);
          check_val("frz_ext_rd", 32'(ext_rd), 32'd0);
          check_val("frz_active", 32'(dma_active), 32'(act));
          if (act && valid) check_val("frz_ext_adr", 32'(ext_adr), 32'(dadr));
          @(posedge clk);
          #1;
        end
      end
      ce = 1'b1;
      t1 = (p == 0);
      @(negedge clk);
      check_val("dma_active", 32'(dma_active), 32'(act));
      chk_din = rd;
      exp_din = 8'hff;
      if (act) begin
        check_val("ext_wr_blk", 32'(ext_wr), 32'd0);
        if (valid) begin
          check_val("dma_ext_adr", 32'(ext_adr), 32'(dadr));
          check_val("dma_ext_rd", 32'(ext_rd), 32'(p != 3));
          check_val("dma_oam_wr", 32'(oam_wr), 32'(p == 3));
          if (p == 3) begin
            check_val("dma_oam_adr", 32'(oam_adr), 32'(dadr[7:0]));
            check_val("dma_oam_dout", 32'(oam_dout), 32'(mem_byte(dadr)));
          end
        end else begin
          check_val("gap_ext_rd", 32'(ext_rd), 32'd0);
          check_val("gap_oam_wr", 32'(oam_wr), 32'd0);
        end
        if (a == 16'hff46) exp_din = last_src;
        else if (a[15:8] == 8'hff) begin
          exp_din = mem_byte(dadr);
          chk_din = rd && valid;
        end
      end else begin
        check_val("cpu_ext_adr", 32'(ext_adr), 32'(a));
        check_val("cpu_ext_rd", 32'(ext_rd), 32'(rd));
        check_val("cpu_ext_wr", 32'(ext_wr), 32'(wr));
        check_val("cpu_oam_wr", 32'(oam_wr), 32'(wr && a >= 16'hfe00 && a <= 16'hfe9f));
        if (a == 16'hff46) exp_din = last_src;
        else if (a >= 16'hfe00 && a <= 16'hfe9f) exp_din = oam_din;
        else if (a[15:8] == 8'hfe) exp_din = 8'h00;
        else exp_din = mem_byte(a);
      end
      if (chk_din) check_val("cpu_din", 32'(cpu_din), 32'(exp_din));
      @(posedge clk);
      #1;
    end
    if (wr && a == 16'hff46) begin
      st_m.push_back(mc);
      st_s.push_back(ref_eff(d));
      last_src = d;
    end
    act_prev = act;
    mc++;
  endtask

  task automatic rand_mcycle(input int freeze_p);
    logic [15:0] adr_tab[6];
    logic [15:0] a;
    int          rw;
    adr_tab[0] = 16'hc000; adr_tab[1] = 16'hfe10; adr_tab[2] = 16'hff80;
    adr_tab[3] = 16'h8123; adr_tab[4] = 16'hfea5; adr_tab[5] = 16'hff46;
    a  = adr_tab[$urandom_range(0, 5)];
    rw = $urandom_range(0, 2);
    if (a == 16'hff46 && rw == 2) rw = 1;
    mcycle(a, rw == 1, rw == 2, 8'($urandom), freeze_p);
  endtask

  task automatic idle_mcycle();
    mcycle(16'h0000, 1'b0, 1'b0, 8'h00, -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k0;
    reset_n = 1'b0; ce = 1'b1; t1 = 1'b0;
    cpu_adr = 16'hc000; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_dout = 8'h00; oam_din = 8'h3c;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_active", 32'(dma_active), 32'd0);
    check_val("rst_ext_rd", 32'(ext_rd), 32'd0);
    check_val("rst_oam_wr", 32'(oam_wr), 32'd0);
    check_val("rst_ext_adr", 32'(ext_adr), 32'd0);
    check_val("rst_oam_adr", 32'(oam_adr), 32'd0);
    check_val("rst_cpu_din", 32'(cpu_din), 32'hff);
    @(posedge clk); #1;
    reset_n = 1'b1; ce = 1'b0;
    @(posedge clk); #1;

    // Pass-through behaviour while idle.
    mcycle(16'hff46, 1'b1, 1'b0, 8'h00, -1);
    mcycle(16'hc000, 1'b1, 1'b0, 8'h00, -1);
    mcycle(16'hfe10, 1'b1, 1'b0, 8'h00, -1);
    mcycle(16'hfea5, 1'b1, 1'b0, 8'h00, -1);
    mcycle(16'hfe20, 1'b0, 1'b1, 8'h77, -1);
    mcycle(16'hc123, 1'b0, 1'b1, 8'h99, -1);

    // Normal transfer from C1xx, with a ce stall in the middle.
    k0 = mc;
    mcycle(16'hff46, 1'b0, 1'b1, 8'hc1, -1);
    idle_mcycle();
    mcycle(16'hc000, 1'b1, 1'b0, 8'h00, -1);
    mcycle(16'hfe10, 1'b1, 1'b0, 8'h00, -1);
    mcycle(16'hff80, 1'b1, 1'b0, 8'h00, -1);
    while (mc < k0 + 30) rand_mcycle(-1);
    rand_mcycle(3);
    while (mc < k0 + 166) rand_mcycle(-1);

    // Echo-window source.
    k0 = mc;
    mcycle(16'hff46, 1'b0, 1'b1, 8'hf0, -1);
    mcycle(16'hff46, 1'b1, 1'b0, 8'h00, -1);
    while (mc < k0 + 164) rand_mcycle(-1);
    mcycle(16'hff46, 1'b1, 1'b0, 8'h00, -1);

    // Restart after 50 bytes: byte 50 still comes from 80xx.
    k0 = mc;
    mcycle(16'hff46, 1'b0, 1'b1, 8'h80, -1);
    while (mc < k0 + 51) rand_mcycle(-1);
    mcycle(16'hff46, 1'b0, 1'b1, 8'hc0, -1);
    while (mc < k0 + 51 + 164) rand_mcycle(-1);

    // Reset in the middle of byte 20.
    k0 = mc;
    mcycle(16'hff46, 1'b0, 1'b1, 8'hc1, -1);
    while (mc < k0 + 22) rand_mcycle(-1);
    cpu_adr = 16'hff46; cpu_rd = 1'b1; cpu_wr = 1'b0;
    ce = 1'b1; t1 = 1'b1;
    @(posedge clk); #1;
    t1 = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mid_rst_active", 32'(dma_active), 32'd0);
    check_val("mid_rst_oam_wr", 32'(oam_wr), 32'd0);
    check_val("mid_rst_ext_rd", 32'(ext_rd), 32'd0);
    check_val("mid_rst_cpu_din", 32'(cpu_din), 32'hff);
    @(posedge clk); #1;
    reset_n = 1'b1; ce = 1'b0;
    @(posedge clk); #1;
    st_m.delete();
    st_s.delete();
    act_prev = 1'b0;
    last_src = 8'hff;
    mc++;
    mcycle(16'hff46, 1'b1, 1'b0, 8'h00, -1);
    repeat (4) idle_mcycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
